// File: rtl/zphoton_gate_counter.sv
// Gate-window photon counter: accumulates quench strobes over back-to-back gates
// of gate_len cycles and hands each total to the readout through a valid/ready register.
module zphoton_gate_counter #(
   parameter int CNT_W  = 32,
   parameter int GATE_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              quench,
   input  logic [GATE_W-1:0] gate_len,
   output logic [CNT_W-1:0]  count_out,
   output logic              count_valid,
   input  logic              count_ready,
   output logic              overflow,
   output logic              lost_gate,
   output logic              busy
);

   typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [GATE_W-1:0] gate_rem_q, gate_rem_d;
   logic [CNT_W-1:0]  acc_q, acc_d, acc_inc;
   logic              acc_ovf_q, acc_ovf_d, ovf_inc;
   logic [CNT_W-1:0]  count_out_q, count_out_d;
   logic              count_valid_q, count_valid_d;
   logic              overflow_q, overflow_d;
   logic              lost_gate_q, lost_gate_d;
   logic              start_ok, last;

   always_comb begin
      start_ok = en && (gate_len != '0);
      last     = (state_q == COUNT) && (gate_rem_q == '0);

      // Saturating increment; acc_inc/ovf_inc include this cycle's strobe.
      acc_inc = acc_q;
      ovf_inc = acc_ovf_q;
      if (quench) begin
         if (&acc_q) ovf_inc = 1'b1;
         else        acc_inc = acc_q + CNT_W'(1);
      end

      state_d    = state_q;
      gate_rem_d = gate_rem_q;
      acc_d      = acc_q;
      acc_ovf_d  = acc_ovf_q;

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d    = COUNT;
               gate_rem_d = gate_len - GATE_W'(1);
               acc_d      = '0;
               acc_ovf_d  = 1'b0;
            end
         end
         COUNT: begin
            if (last) begin
               acc_d      = '0;
               acc_ovf_d  = 1'b0;
               gate_rem_d = start_ok ? gate_len - GATE_W'(1) : '0;
               if (!start_ok) state_d = IDLE;
            end else if (!en) begin
               state_d    = IDLE;
               gate_rem_d = '0;
               acc_d      = '0;
               acc_ovf_d  = 1'b0;
            end else begin
               gate_rem_d = gate_rem_q - GATE_W'(1);
               acc_d      = acc_inc;
               acc_ovf_d  = ovf_inc;
            end
         end
         default: state_d = IDLE;
      endcase

      count_out_d   = count_out_q;
      count_valid_d = count_valid_q;
      overflow_d    = overflow_q;
      lost_gate_d   = lost_gate_q;
      // A commit wins over an accept in the same cycle; overwriting an unread result is sticky-flagged.
      if (last) begin
         count_out_d   = acc_inc;
         overflow_d    = ovf_inc;
         count_valid_d = 1'b1;
         if (count_valid_q && !count_ready) lost_gate_d = 1'b1;
      end else if (count_valid_q && count_ready) begin
         count_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         gate_rem_q    <= '0;
         acc_q         <= '0;
         acc_ovf_q     <= 1'b0;
         count_out_q   <= '0;
         count_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
         lost_gate_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         gate_rem_q    <= gate_rem_d;
         acc_q         <= acc_d;
         acc_ovf_q     <= acc_ovf_d;
         count_out_q   <= count_out_d;
         count_valid_q <= count_valid_d;
         overflow_q    <= overflow_d;
         lost_gate_q   <= lost_gate_d;
      end
   end

   assign count_out   = count_out_q;
   assign count_valid = count_valid_q;
   assign overflow    = overflow_q;
   assign lost_gate   = lost_gate_q;
   assign busy        = (state_q == COUNT);

endmodule

// File: tb/tb_zphoton_gate_counter.sv
// Bench for zphoton_gate_counter: vector table, directed gate scenarios and random
// traffic, all checked against a gate-level behavioural model.
module tb_zphoton_gate_counter;

   localparam int CNT_W  = 4;
   localparam int GATE_W = 8;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n, en, quench, count_ready;
   logic [GATE_W-1:0] gate_len;
   logic [CNT_W-1:0]  count_out;
   logic              count_valid, overflow, lost_gate, busy;

   int checks = 0;
   int errors = 0;

   // Model state: whether a gate is open, its length, position and raw strobe count.
   bit m_in, m_valid, m_ovf, m_lost;
   int m_len, m_idx, m_n, m_out;

   zphoton_gate_counter #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .quench(quench), .gate_len(gate_len),
      .count_out(count_out), .count_valid(count_valid), .count_ready(count_ready),
      .overflow(overflow), .lost_gate(lost_gate), .busy(busy)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic       rst_n, en, q;
      logic [7:0] gl;
      logic       rdy;
      logic       ev;
      logic [3:0] eo;
      logic       eovf, elost, ebusy;
   } vec_t;
   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic q, input int gl, input logic rd);
      rst_n = r; en = e; quench = q; gate_len = GATE_W'(gl); count_ready = rd;
   endtask

   task automatic model_step();
      bit commit;
      int res;
      bit rov;
      commit = 0; res = 0; rov = 0;
      if (!rst_n) begin
         m_in = 0; m_len = 0; m_idx = 0; m_n = 0;
         m_out = 0; m_valid = 0; m_ovf = 0; m_lost = 0;
         return;
      end
      if (!m_in) begin
         if (en && gate_len != 0) begin
            m_in = 1; m_len = int'(gate_len); m_idx = 0; m_n = 0;
         end
      end else begin
         m_n += int'(quench);
         if (m_idx == m_len - 1) begin
            commit = 1;
            res = (m_n > CMAX) ? CMAX : m_n;
            rov = (m_n > CMAX);
            if (en && gate_len != 0) begin
               m_len = int'(gate_len); m_idx = 0; m_n = 0;
            end else m_in = 0;
         end else if (!en) m_in = 0;
         else m_idx++;
      end
      if (commit) begin
         if (m_valid && !count_ready) m_lost = 1;
         m_valid = 1; m_out = res; m_ovf = rov;
      end else if (m_valid && count_ready) m_valid = 0;
   endtask

   // One clock: model sees the same inputs as the DUT, outputs compared after the edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("model valid",     32'(count_valid), 32'(m_valid));
      chk("model count_out", 32'(count_out),   32'(m_out));
      chk("model overflow",  32'(overflow),    32'(m_ovf));
      chk("model lost_gate", 32'(lost_gate),   32'(m_lost));
      chk("model busy",      32'(busy),        32'(m_in));
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      cycle();
      cycle();
   endtask

   initial begin
      //          rst en q  gl rdy   v  out ovf lost busy
      vecs[0]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
      vecs[1]  = '{1, 1, 0, 0, 0,   0, 0, 0, 0, 0};
      vecs[2]  = '{1, 1, 1, 1, 1,   0, 0, 0, 0, 1};
      vecs[3]  = '{1, 1, 1, 1, 1,   1, 1, 0, 0, 1};
      vecs[4]  = '{1, 1, 0, 1, 1,   1, 0, 0, 0, 1};
      vecs[5]  = '{1, 1, 1, 1, 1,   1, 1, 0, 0, 1};
      vecs[6]  = '{1, 0, 0, 1, 1,   1, 0, 0, 0, 0};
      vecs[7]  = '{1, 0, 0, 1, 1,   0, 0, 0, 0, 0};
      vecs[8]  = '{1, 1, 0, 2, 0,   0, 0, 0, 0, 1};
      vecs[9]  = '{1, 1, 1, 2, 0,   0, 0, 0, 0, 1};
      vecs[10] = '{1, 1, 1, 2, 0,   1, 2, 0, 0, 1};
      vecs[11] = '{1, 1, 0, 2, 0,   1, 2, 0, 0, 1};
      vecs[12] = '{1, 1, 0, 2, 0,   1, 0, 0, 1, 1};
      vecs[13] = '{1, 0, 0, 2, 1,   0, 0, 0, 1, 0};

      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].q, int'(vecs[i].gl), vecs[i].rdy);
         cycle();
         chk($sformatf("vec%0d valid", i), 32'(count_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d out", i),   32'(count_out),   32'(vecs[i].eo));
         chk($sformatf("vec%0d ovf", i),   32'(overflow),    32'(vecs[i].eovf));
         chk($sformatf("vec%0d lost", i),  32'(lost_gate),   32'(vecs[i].elost));
         chk($sformatf("vec%0d busy", i),  32'(busy),        32'(vecs[i].ebusy));
      end

      // T1: strobes in gate cycles 2,5,9 of a 10-cycle gate.
      do_reset();
      chk("t1 reset valid", 32'(count_valid), 0);
      chk("t1 reset busy",  32'(busy), 0);
      drive(1, 1, 0, 10, 1);
      cycle();
      for (int c = 0; c < 10; c++) begin
         quench = (c == 2 || c == 5 || c == 9);
         cycle();
         if (c < 9) chk("t1 no early valid", 32'(count_valid), 0);
      end
      chk("t1 valid", 32'(count_valid), 1);
      chk("t1 count", 32'(count_out), 3);
      chk("t1 ovf",   32'(overflow), 0);
      drive(1, 0, 0, 10, 1);
      cycle();
      chk("t1 valid pulse", 32'(count_valid), 0);

      // T2: saturation, then a clean gate.
      do_reset();
      drive(1, 1, 0, 30, 1);
      cycle();
      quench = 1;
      for (int c = 0; c < 30; c++) cycle();
      chk("t2 sat count", 32'(count_out), 15);
      chk("t2 sat ovf",   32'(overflow), 1);
      for (int c = 0; c < 30; c++) begin
         quench = (c < 3);
         cycle();
      end
      chk("t2 count", 32'(count_out), 3);
      chk("t2 ovf",   32'(overflow), 0);
      chk("t2 valid", 32'(count_valid), 1);

      // T3: overwrite of an unread result.
      do_reset();
      drive(1, 1, 0, 4, 0);
      cycle();
      for (int c = 0; c < 8; c++) begin
         quench = (c == 0 || c == 4 || c == 5);
         cycle();
      end
      chk("t3 count", 32'(count_out), 2);
      chk("t3 lost",  32'(lost_gate), 1);
      chk("t3 valid held", 32'(count_valid), 1);
      drive(1, 0, 0, 4, 1);
      cycle();
      chk("t3 valid after accept", 32'(count_valid), 0);
      chk("t3 lost sticky", 32'(lost_gate), 1);
      count_ready = 0;

      // T4: abort at cycle 50, then a fresh gate.
      do_reset();
      drive(1, 1, 0, 100, 1);
      cycle();
      for (int c = 0; c < 50; c++) begin
         quench = (c < 7);
         cycle();
      end
      en = 0;
      cycle();
      chk("t4 abort busy",  32'(busy), 0);
      chk("t4 abort valid", 32'(count_valid), 0);
      en = 1;
      cycle();
      for (int c = 0; c < 100; c++) begin
         quench = (c == 10 || c == 50);
         cycle();
      end
      chk("t4 fresh count", 32'(count_out), 2);
      chk("t4 fresh valid", 32'(count_valid), 1);

      // T6: zero length stays idle; reset mid-gate clears everything.
      do_reset();
      drive(1, 1, 1, 0, 1);
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("t6 gl0 busy",  32'(busy), 0);
         chk("t6 gl0 valid", 32'(count_valid), 0);
      end
      drive(1, 1, 1, 2, 0);
      for (int c = 0; c < 6; c++) cycle();
      chk("t6 lost before reset", 32'(lost_gate), 1);
      rst_n = 0;
      cycle();
      chk("t6 rst valid", 32'(count_valid), 0);
      chk("t6 rst out",   32'(count_out), 0);
      chk("t6 rst lost",  32'(lost_gate), 0);
      chk("t6 rst busy",  32'(busy), 0);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int sel;
         sel = int'($urandom_range(0, 5));
         rst_n       = ($urandom_range(0, 199) != 0);
         en          = ($urandom_range(0, 24) != 0);
         quench      = ($urandom_range(0, 3) != 0);
         count_ready = $urandom_range(0, 1) == 1;
         case (sel)
            0: gate_len = 0;
            1: gate_len = 1;
            2: gate_len = 2;
            3: gate_len = 3;
            4: gate_len = 5;
            default: gate_len = 20;
         endcase
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
